// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the I/D Avalon-MM bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
    typedef enum logic {REQ_I, REQ_D} req_id_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/bus_watchdog.sv
// Counts consecutive stalled bus cycles; expired is high once TIMEOUT is reached.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Saturates at LIMIT so a held-off clear cannot wrap the counter.
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (count_en && count != LIMIT)
            count <= count + 1'b1;
    end

    assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Shares one Avalon-MM master between fetch (I) and load/store (D) requesters,
// alternating under contention and reporting stuck-bus timeouts.
module avalon_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       TIMEOUT  = 1023,
    parameter logic [DATA_W-1:0] ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata,
    output logic [1:0]          grant,
    output logic                bus_error
);

    arb_state_t state, state_next;
    req_id_t    last_grant, last_grant_next;
    logic       set_error;
    logic       wd_clear, wd_count_en, wd_expired;

    logic req_i, req_d;
    assign req_i = i_read;
    assign req_d = d_read | d_write;

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expired  (wd_expired)
    );

    assign wd_clear = (state == IDLE) || (state_next != state);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= REQ_D;
            bus_error  <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            bus_error  <= bus_error | set_error;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        set_error       = 1'b0;
        wd_count_en     = 1'b0;
        address         = '0;
        read            = 1'b0;
        write           = 1'b0;
        writedata       = '0;
        byteenable      = '0;
        grant           = GRANT_NONE;
        i_waitrequest   = 1'b1;
        d_waitrequest   = 1'b1;
        i_readdata      = readdata;
        d_readdata      = readdata;

        case (state)
            IDLE: begin
                if (req_i && (!req_d || last_grant == REQ_D))
                    state_next = BUSY_I;
                else if (req_d)
                    state_next = BUSY_D;
            end

            BUSY_I: begin
                grant      = GRANT_I;
                address    = i_address;
                byteenable = '1;
                // Timeout wins over a late completion: the command is withdrawn this cycle.
                if (wd_expired) begin
                    i_waitrequest   = 1'b0;
                    i_readdata      = ERR_DATA;
                    set_error       = 1'b1;
                    last_grant_next = REQ_I;
                    state_next      = IDLE;
                end else if (!req_i) begin
                    state_next = IDLE;
                end else begin
                    read          = 1'b1;
                    i_waitrequest = waitrequest;
                    wd_count_en   = waitrequest;
                    if (!waitrequest) begin
                        last_grant_next = REQ_I;
                        state_next      = req_d ? BUSY_D : IDLE;
                    end
                end
            end

            BUSY_D: begin
                grant      = GRANT_D;
                address    = d_address;
                writedata  = d_writedata;
                byteenable = d_byteenable;
                if (wd_expired) begin
                    d_waitrequest   = 1'b0;
                    d_readdata      = ERR_DATA;
                    set_error       = 1'b1;
                    last_grant_next = REQ_D;
                    state_next      = IDLE;
                end else if (!req_d) begin
                    state_next = IDLE;
                end else begin
                    read          = d_read;
                    write         = d_write;
                    d_waitrequest = waitrequest;
                    wd_count_en   = waitrequest;
                    if (!waitrequest) begin
                        last_grant_next = REQ_D;
                        state_next      = req_i ? BUSY_I : IDLE;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter with a scoreboard of expected transfer endings.
module tb_avalon_bus_arbiter;
    import bus_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [1:0]  grant;
    logic        bus_error;

    avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_waitrequest (i_waitrequest),
        .i_readdata    (i_readdata),
        .d_address     (d_address),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_writedata   (d_writedata),
        .d_byteenable  (d_byteenable),
        .d_waitrequest (d_waitrequest),
        .d_readdata    (d_readdata),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .grant         (grant),
        .bus_error     (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  grant;
        logic        rd;
        logic        wr;
        logic        chk_addr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic rd, input logic wr, input logic ca,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] rdat);
        exp_t e;
        e.grant = g; e.rd = rd; e.wr = wr; e.chk_addr = ca;
        e.addr = a; e.wdata = wd; e.be = be; e.rdata = rdat;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard: a transfer ends whenever some requester sees waitrequest low.
    exp_t mon_e;
    logic mon_ev;
    always @(negedge clk) begin
        if (!reset) begin
            mon_ev = (grant == GRANT_I && !i_waitrequest) ||
                     (grant == GRANT_D && !d_waitrequest) ||
                     (grant != GRANT_I && !i_waitrequest) ||
                     (grant != GRANT_D && !d_waitrequest);
            if (mon_ev) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_end", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_grant", {30'd0, grant}, {30'd0, mon_e.grant});
                    chk("sb_read", {31'd0, read}, {31'd0, mon_e.rd});
                    chk("sb_write", {31'd0, write}, {31'd0, mon_e.wr});
                    chk("sb_byteenable", {28'd0, byteenable}, {28'd0, mon_e.be});
                    chk("sb_writedata", writedata, mon_e.wdata);
                    if (mon_e.chk_addr)
                        chk("sb_address", address, mon_e.addr);
                    if (mon_e.grant == GRANT_I) begin
                        chk("sb_i_readdata", i_readdata, mon_e.rdata);
                        chk("sb_d_wait_other", {31'd0, d_waitrequest}, 32'd1);
                    end else begin
                        chk("sb_d_readdata", d_readdata, mon_e.rdata);
                        chk("sb_i_wait_other", {31'd0, i_waitrequest}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        i_address = '0; i_read = 1'b0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0;
        d_writedata = '0; d_byteenable = '0;
        waitrequest = 1'b0; readdata = '0;

        // Reset then idle
        tick(); tick();
        reset = 1'b0;
        sample();
        chk("idle_read", {31'd0, read}, 32'd0);
        chk("idle_write", {31'd0, write}, 32'd0);
        chk("idle_grant", {30'd0, grant}, 32'd0);
        chk("idle_i_wait", {31'd0, i_waitrequest}, 32'd1);
        chk("idle_d_wait", {31'd0, d_waitrequest}, 32'd1);
        chk("idle_bus_error", {31'd0, bus_error}, 32'd0);
        chk("idle_address", address, 32'd0);
        chk("idle_be", {28'd0, byteenable}, 32'd0);

        // Single fetch, zero wait
        tick();
        i_read = 1'b1; i_address = 32'h100; readdata = 32'h12345678; waitrequest = 1'b0;
        push(GRANT_I, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF, 32'h12345678);
        sample();
        chk("t1_arb_grant", {30'd0, grant}, 32'd0);
        chk("t1_arb_i_wait", {31'd0, i_waitrequest}, 32'd1);
        tick();
        sample();
        chk("t1_grant", {30'd0, grant}, {30'd0, GRANT_I});
        chk("t1_i_wait", {31'd0, i_waitrequest}, 32'd0);
        tick();
        i_read = 1'b0;
        sample();
        chk("t1_back_idle", {30'd0, grant}, 32'd0);
        chk("t1_read_low", {31'd0, read}, 32'd0);

        // Contention straight after reset: I first, then D with no idle gap
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_read = 1'b1; i_address = 32'h300;
        d_write = 1'b1; d_address = 32'h200; d_writedata = 32'hCAFEF00D; d_byteenable = 4'b0011;
        readdata = 32'hA5A5A5A5;
        push(GRANT_I, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 4'hF, 32'hA5A5A5A5);
        push(GRANT_D, 1'b0, 1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'b0011, 32'hA5A5A5A5);
        sample();
        chk("t2_arb_grant", {30'd0, grant}, 32'd0);
        tick();
        sample();
        chk("t2_grant_i", {30'd0, grant}, {30'd0, GRANT_I});
        chk("t2_d_held", {31'd0, d_waitrequest}, 32'd1);
        tick();
        i_read = 1'b0;
        sample();
        chk("t2_grant_d", {30'd0, grant}, {30'd0, GRANT_D});
        chk("t2_write", {31'd0, write}, 32'd1);
        tick();
        d_write = 1'b0; d_writedata = '0; d_byteenable = 4'hF;
        sample();
        chk("t2_back_idle", {30'd0, grant}, 32'd0);

        // D read stalled 3 cycles while I waits
        tick();
        d_read = 1'b1; d_address = 32'h400; waitrequest = 1'b1;
        push(GRANT_D, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 4'hF, 32'h0BADF00D);
        sample();
        tick();
        i_read = 1'b1; i_address = 32'h500;
        push(GRANT_I, 1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 4'hF, 32'h11112222);
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("t3_stall_grant", {30'd0, grant}, {30'd0, GRANT_D});
            chk("t3_stall_d_wait", {31'd0, d_waitrequest}, 32'd1);
            chk("t3_stall_i_wait", {31'd0, i_waitrequest}, 32'd1);
            tick();
        end
        waitrequest = 1'b0; readdata = 32'h0BADF00D;
        sample();
        chk("t3_d_done_grant", {30'd0, grant}, {30'd0, GRANT_D});
        tick();
        d_read = 1'b0; readdata = 32'h11112222;
        sample();
        chk("t3_i_grant", {30'd0, grant}, {30'd0, GRANT_I});
        tick();
        i_read = 1'b0;
        sample();
        chk("t3_back_idle", {30'd0, grant}, 32'd0);

        // Watchdog timeout on a stuck D read
        tick();
        d_read = 1'b1; d_address = 32'h600; waitrequest = 1'b1; readdata = 32'h55555555;
        push(GRANT_D, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0, 4'hF, 32'hDEADBEEF);
        sample();
        tick();
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("t4_stall_d_wait", {31'd0, d_waitrequest}, 32'd1);
            chk("t4_stall_read", {31'd0, read}, 32'd1);
            tick();
        end
        sample();
        chk("t4_timeout_read", {31'd0, read}, 32'd0);
        chk("t4_timeout_err_not_yet", {31'd0, bus_error}, 32'd0);
        tick();
        d_read = 1'b0; waitrequest = 1'b0;
        sample();
        chk("t4_bus_error", {31'd0, bus_error}, 32'd1);
        chk("t4_idle_grant", {30'd0, grant}, 32'd0);
        tick();
        i_read = 1'b1; i_address = 32'h700; readdata = 32'h33334444;
        push(GRANT_I, 1'b1, 1'b0, 1'b1, 32'h700, 32'h0, 4'hF, 32'h33334444);
        sample();
        tick();
        sample();
        chk("t4_later_grant", {30'd0, grant}, {30'd0, GRANT_I});
        tick();
        i_read = 1'b0;
        sample();
        chk("t4_error_sticky", {31'd0, bus_error}, 32'd1);

        // Reset while D write is stalled
        tick();
        d_write = 1'b1; d_address = 32'h800; d_writedata = 32'h77777777; waitrequest = 1'b1;
        sample();
        tick();
        reset = 1'b1;
        sample();
        chk("t5_busy_grant", {30'd0, grant}, {30'd0, GRANT_D});
        chk("t5_busy_write", {31'd0, write}, 32'd1);
        tick();
        sample();
        chk("t5_rst_write", {31'd0, write}, 32'd0);
        chk("t5_rst_grant", {30'd0, grant}, 32'd0);
        chk("t5_rst_d_wait", {31'd0, d_waitrequest}, 32'd1);
        chk("t5_rst_bus_error", {31'd0, bus_error}, 32'd0);
        tick();
        reset = 1'b0; d_write = 1'b0; waitrequest = 1'b0;
        sample();
        chk("t5_after_grant", {30'd0, grant}, 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
